// File: rtl/range_checker.sv
// Sequential range lookup: scans the low/high bound ROMs in index order for one ID at a time
// and reports the first inclusive range containing it, plus a running count of in-range hits.
module range_checker #(
    parameter int NUM_RANGES  = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [DATA_WIDTH-1:0]  id_data,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  low_bound,
    input  logic [DATA_WIDTH-1:0]  high_bound,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_in_range,
    output logic [ADDR_WIDTH-1:0]  res_index,
    output logic [COUNT_WIDTH-1:0] fresh_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_RANGES - 1);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] id_q;
    logic                  hit;

    // Both ends inclusive; a degenerate range (low > high) can never satisfy both.
    assign hit       = (low_bound <= id_q) && (id_q <= high_bound);
    assign id_ready  = (state == IDLE);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            id_q         <= '0;
            rom_addr     <= '0;
            res_in_range <= 1'b0;
            res_index    <= '0;
            fresh_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_valid) begin
                        id_q     <= id_data;
                        rom_addr <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        res_in_range <= 1'b1;
                        res_index    <= rom_addr;
                        state        <= DONE;
                    end else if (rom_addr == LAST_ADDR) begin
                        res_in_range <= 1'b0;
                        res_index    <= '0;
                        state        <= DONE;
                    end else begin
                        rom_addr <= rom_addr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        // Count saturates rather than wrapping.
                        if (res_in_range && (fresh_count != '1))
                            fresh_count <= fresh_count + COUNT_WIDTH'(1);
                        rom_addr <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_checker.sv
// Directed bench for range_checker: four fixed ranges [3,5],[10,14],[16,20],[12,18].
module tb_range_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_data;
    logic [1:0]  rom_addr;
    logic [7:0]  low_bound;
    logic [7:0]  high_bound;
    logic        res_valid;
    logic        res_ready;
    logic        res_in_range;
    logic [1:0]  res_index;
    logic [31:0] fresh_count;

    logic [7:0] lows  [4] = '{8'd3, 8'd10, 8'd16, 8'd12};
    logic [7:0] highs [4] = '{8'd5, 8'd14, 8'd20, 8'd18};

    int n_checks = 0;
    int n_errors = 0;

    assign low_bound  = lows[rom_addr];
    assign high_bound = highs[rom_addr];

    always #5 clk = ~clk;

    range_checker #(
        .NUM_RANGES (4),
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .COUNT_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_data     (id_data),
        .rom_addr    (rom_addr),
        .low_bound   (low_bound),
        .high_bound  (high_bound),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_in_range(res_in_range),
        .res_index   (res_index),
        .fresh_count (fresh_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one ID, then return the cycle index in which res_valid first rises.
    task automatic send_id(input logic [7:0] id, output int cyc);
        id_valid = 1'b1;
        id_data  = id;
        tick();
        id_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_id(input string tag, input logic [7:0] id, input logic exp_hit,
                          input logic [1:0] exp_idx, input int exp_cyc, input logic [31:0] exp_cnt);
        int cyc;
        send_id(id, cyc);
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " in_range"}, res_in_range, exp_hit);
        check({tag, " index"}, res_index, exp_idx);
        check({tag, " busy"}, id_ready, 1'b0);
        tick();
        check({tag, " count"}, fresh_count, exp_cnt);
        check({tag, " released"}, res_valid, 1'b0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_data   = '0;
        res_ready = 1'b1;
        tick();
        tick();
        check("rst id_ready", id_ready, 1'b1);
        check("rst res_valid", res_valid, 1'b0);
        check("rst rom_addr", rom_addr, 2'd0);
        check("rst count", fresh_count, 0);
        rst_n = 1'b1;
        tick();

        run_id("id5",  8'd5,  1'b1, 2'd0, 1, 1);
        run_id("id17", 8'd17, 1'b1, 2'd2, 3, 2);
        run_id("id1",  8'd1,  1'b0, 2'd0, 4, 2);
        run_id("id15", 8'd15, 1'b1, 2'd3, 4, 3);
        run_id("id21", 8'd21, 1'b0, 2'd0, 4, 3);
        run_id("id3",  8'd3,  1'b1, 2'd0, 1, 4);
        run_id("id20", 8'd20, 1'b1, 2'd2, 3, 5);

        // Backpressure: result must hold while res_ready is low, busy ID ignored.
        res_ready = 1'b0;
        send_id(8'd10, cyc);
        check("hold latency", cyc, 2);
        id_valid = 1'b1;
        id_data  = 8'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold valid", res_valid, 1'b1);
            check("hold index", res_index, 2'd1);
            check("hold in_range", res_in_range, 1'b1);
            check("hold id_ready", id_ready, 1'b0);
            check("hold count", fresh_count, 5);
        end
        id_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        check("release count", fresh_count, 6);
        check("release valid", res_valid, 1'b0);
        check("release id_ready", id_ready, 1'b1);

        // Reset mid-scan at rom_addr 2 discards the transaction.
        id_valid = 1'b1;
        id_data  = 8'd100;
        tick();
        id_valid = 1'b0;
        tick();
        tick();
        check("scan addr", rom_addr, 2'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid rst id_ready", id_ready, 1'b1);
        check("mid rst addr", rom_addr, 2'd0);
        check("mid rst count", fresh_count, 0);
        tick();
        check("mid rst no result", res_valid, 1'b0);
        run_id("id12", 8'd12, 1'b1, 2'd1, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
